// File: rtl/nukv_fb_arbiter.sv
// Feedback/regular stream merger for the nukv pipeline head.
// Feedback wins with a bounded burst; regular admission is credit-capped.
module nukv_fb_arbiter #(
   parameter int KEY_WIDTH    = 128,
   parameter int META_WIDTH   = 96,
   parameter int MAX_FB_BURST = 4,
   parameter int MAX_INFLIGHT = 16,
   parameter int CNT_WIDTH    = 5
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [KEY_WIDTH+META_WIDTH-1:0] fb_in_data,
   input  logic                            fb_in_valid,
   output logic                            fb_in_ready,
   input  logic [KEY_WIDTH+META_WIDTH-1:0] reg_in_data,
   input  logic                            reg_in_valid,
   output logic                            reg_in_ready,
   output logic [KEY_WIDTH+META_WIDTH-1:0] out_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            out_src,
   input  logic                            retire_valid,
   output logic [CNT_WIDTH-1:0]            inflight_count,
   output logic                            retire_err
);

   localparam int W  = KEY_WIDTH + META_WIDTH;
   localparam int SW = $clog2(MAX_FB_BURST + 1);
   localparam logic [SW-1:0]        BURST = SW'(MAX_FB_BURST);
   localparam logic [CNT_WIDTH-1:0] CAP   = CNT_WIDTH'(MAX_INFLIGHT);
   localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);
   localparam logic [SW-1:0]        SONE  = SW'(1);

   logic                 r_out_valid;
   logic [W-1:0]         r_out_data;
   logic                 r_out_src;
   logic [SW-1:0]        r_streak;
   logic [CNT_WIDTH-1:0] r_inflight;
   logic                 r_retire_err;

   logic w_load_en;
   logic w_fb_elig;
   logic w_reg_elig;
   logic w_streak_sat;
   logic w_grant_fb;
   logic w_grant_reg;
   logic w_any_grant;
   logic w_cnt_zero;

   assign w_load_en    = !r_out_valid || out_ready;
   assign w_fb_elig    = fb_in_valid;
   assign w_reg_elig   = reg_in_valid && (r_inflight < CAP);
   assign w_streak_sat = (r_streak == BURST);
   assign w_cnt_zero   = (r_inflight == '0);

   // Saturated streak hands one slot to a waiting regular word.
   always_comb begin
      w_grant_fb  = 1'b0;
      w_grant_reg = 1'b0;
      if (w_load_en) begin
         if (w_fb_elig && w_reg_elig && w_streak_sat) begin
            w_grant_reg = 1'b1;
         end else if (w_fb_elig) begin
            w_grant_fb = 1'b1;
         end else if (w_reg_elig) begin
            w_grant_reg = 1'b1;
         end
      end
   end

   assign w_any_grant  = w_grant_fb || w_grant_reg;
   assign fb_in_ready  = rst && w_grant_fb;
   assign reg_in_ready = rst && w_grant_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_src   <= 1'b0;
      end else if (w_load_en) begin
         r_out_valid <= w_any_grant;
         if (w_grant_fb) begin
            r_out_data <= fb_in_data;
            r_out_src  <= 1'b1;
         end else if (w_grant_reg) begin
            r_out_data <= reg_in_data;
            r_out_src  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_streak <= '0;
      end else if (w_grant_reg) begin
         r_streak <= '0;
      end else if (w_grant_fb && !w_streak_sat) begin
         r_streak <= r_streak + SONE;
      end
   end

   // Retire against an empty counter is a protocol error, not an underflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_inflight   <= '0;
         r_retire_err <= 1'b0;
      end else begin
         if (w_grant_reg && !retire_valid) begin
            r_inflight <= r_inflight + ONE;
         end else if (!w_grant_reg && retire_valid) begin
            if (w_cnt_zero) begin
               r_retire_err <= 1'b1;
            end else begin
               r_inflight <= r_inflight - ONE;
            end
         end
      end
   end

   assign out_valid      = r_out_valid;
   assign out_data       = r_out_data;
   assign out_src        = r_out_src;
   assign inflight_count = r_inflight;
   assign retire_err     = r_retire_err;

endmodule

// File: tb/tb_nukv_fb_arbiter.sv
// Bench for nukv_fb_arbiter: directed scenarios plus a randomized
// run checked against a queue-based model of the merge rules.
module tb_nukv_fb_arbiter;

   localparam int KW    = 128;
   localparam int MW    = 96;
   localparam int W     = KW + MW;
   localparam int BURST = 4;
   localparam int CAP   = 16;
   localparam int CW    = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  fb_in_data;
   logic          fb_in_valid;
   logic          fb_in_ready;
   logic [W-1:0]  reg_in_data;
   logic          reg_in_valid;
   logic          reg_in_ready;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_src;
   logic          retire_valid;
   logic [CW-1:0] inflight_count;
   logic          retire_err;

   always #5 clk = ~clk;

   nukv_fb_arbiter #(
      .KEY_WIDTH(KW), .META_WIDTH(MW), .MAX_FB_BURST(BURST),
      .MAX_INFLIGHT(CAP), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .fb_in_data(fb_in_data), .fb_in_valid(fb_in_valid),
      .fb_in_ready(fb_in_ready),
      .reg_in_data(reg_in_data), .reg_in_valid(reg_in_valid),
      .reg_in_ready(reg_in_ready),
      .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_src(out_src),
      .retire_valid(retire_valid), .inflight_count(inflight_count),
      .retire_err(retire_err)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic         src;
      logic [W-1:0] data;
   } ent_t;
   typedef enum int {P_NONE, P_FB, P_REG} pick_t;

   ent_t  q[$];
   bit    m_ov;
   int    m_streak;
   int    m_cnt;
   bit    m_err;
   pick_t pick;
   bit    have_prev;
   bit    e_fb_rdy;
   bit    e_reg_rdy;

   function automatic logic [W-1:0] rnd_word();
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < (W + 31) / 32; i++) v = (v << 32) | W'($urandom);
      return v;
   endfunction

   task automatic model_reset();
      q.delete();
      m_ov = 0; m_streak = 0; m_cnt = 0; m_err = 0;
      pick = P_NONE; have_prev = 0;
   endtask

   task automatic model_eval();
      bit load, fok, rok;
      load = !m_ov || out_ready;
      fok  = fb_in_valid;
      rok  = reg_in_valid && (m_cnt < CAP);
      pick = P_NONE;
      if (load) begin
         if (fok && rok && m_streak == BURST) pick = P_REG;
         else if (fok) pick = P_FB;
         else if (rok) pick = P_REG;
      end
      e_fb_rdy  = (pick == P_FB);
      e_reg_rdy = (pick == P_REG);
   endtask

   task automatic model_commit();
      bit load;
      load = !m_ov || out_ready;
      if (m_ov && out_ready && q.size() > 0) void'(q.pop_front());
      if (pick == P_FB) begin
         q.push_back('{1'b1, fb_in_data});
         m_streak = (m_streak + 1 > BURST) ? BURST : m_streak + 1;
      end else if (pick == P_REG) begin
         q.push_back('{1'b0, reg_in_data});
         m_streak = 0;
      end
      if (pick != P_NONE) m_ov = 1;
      else if (load) m_ov = 0;
      if (retire_valid && pick != P_REG) begin
         if (m_cnt == 0) m_err = 1;
         else m_cnt--;
      end else if (!retire_valid && pick == P_REG) begin
         m_cnt++;
      end
   endtask

   task automatic drive(input bit fv, input logic [W-1:0] fd,
                        input bit rv, input logic [W-1:0] rd,
                        input bit ordy, input bit ret);
      @(negedge clk);
      if (have_prev) model_commit();
      fb_in_valid  = fv;
      fb_in_data   = fd;
      reg_in_valid = rv;
      reg_in_data  = rd;
      out_ready    = ordy;
      retire_valid = ret;
      #1;
      model_eval();
      have_prev = 1;
   endtask

   task automatic idle_inputs();
      fb_in_valid = 0; reg_in_valid = 0; retire_valid = 0;
      out_ready = 1; fb_in_data = '0; reg_in_data = '0;
   endtask

   task automatic do_reset();
      rst = 0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst = 1;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 0;
      fb_in_valid = 1; reg_in_valid = 1; out_ready = 1; retire_valid = 0;
      fb_in_data = rnd_word(); reg_in_data = rnd_word();
      @(posedge clk);
      #1;
      checks++; if (fb_in_ready !== 1'b0) begin failures++; $display("FAIL rst_fb_rdy got=%0b exp=0", fb_in_ready); end
      checks++; if (reg_in_ready !== 1'b0) begin failures++; $display("FAIL rst_reg_rdy got=%0b exp=0", reg_in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
      checks++; if (out_data !== '0) begin failures++; $display("FAIL rst_out_data got=%0h exp=0", out_data); end
      checks++; if (out_src !== 1'b0) begin failures++; $display("FAIL rst_out_src got=%0b exp=0", out_src); end
      checks++; if (inflight_count !== '0) begin failures++; $display("FAIL rst_count got=%0d exp=0", inflight_count); end
      checks++; if (retire_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", retire_err); end
      idle_inputs();
      @(negedge clk);
      rst = 1;
      model_reset();
   endtask

   task automatic test_reg_abc();
      logic [W-1:0] w[3];
      for (int i = 0; i < 3; i++) w[i] = rnd_word();
      for (int i = 0; i < 4; i++) begin
         drive(0, '0, i < 3, (i < 3) ? w[i % 3] : '0, 1, 0);
         if (i < 3) begin
            checks++; if (reg_in_ready !== 1'b1) begin failures++; $display("FAIL abc_rdy%0d got=%0b exp=1", i, reg_in_ready); end
         end
         if (i > 0) begin
            checks++; if (out_valid !== 1'b1 || out_data !== w[i-1] || out_src !== 1'b0) begin
               failures++; $display("FAIL abc_out%0d got=%0b/%0h/%0b exp=1/%0h/0", i, out_valid, out_data, out_src, w[i-1]);
            end
         end
      end
      checks++; if (inflight_count !== 5'd3) begin failures++; $display("FAIL abc_count got=%0d exp=3", inflight_count); end
      repeat (3) drive(0, '0, 0, '0, 1, 1);
      drive(0, '0, 0, '0, 1, 0);
      checks++; if (inflight_count !== 5'd0) begin failures++; $display("FAIL abc_drain got=%0d exp=0", inflight_count); end
   endtask

   task automatic test_burst();
      bit exp_fb[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      logic [W-1:0] fw, rw;
      fw = rnd_word(); rw = rnd_word();
      for (int i = 0; i < 10; i++) begin
         drive(1, fw, 1, rw, 1, 0);
         checks++; if (fb_in_ready !== exp_fb[i] || reg_in_ready !== !exp_fb[i]) begin
            failures++; $display("FAIL burst_grant%0d got=fb%0b/reg%0b exp=fb%0b", i, fb_in_ready, reg_in_ready, exp_fb[i]);
         end
         if (i > 0) begin
            checks++; if (out_src !== exp_fb[i-1]) begin failures++; $display("FAIL burst_src%0d got=%0b exp=%0b", i, out_src, exp_fb[i-1]); end
         end
         if (exp_fb[i]) fw = rnd_word();
         else rw = rnd_word();
      end
      drive(0, '0, 0, '0, 1, 1);
      checks++; if (out_src !== 1'b0 || inflight_count !== 5'd2) begin
         failures++; $display("FAIL burst_tail got=src%0b/cnt%0d exp=src0/cnt2", out_src, inflight_count);
      end
      drive(0, '0, 0, '0, 1, 1);
      drive(0, '0, 0, '0, 1, 0);
   endtask

   task automatic test_cap();
      logic [W-1:0] w17;
      w17 = rnd_word();
      for (int i = 0; i < 16; i++) begin
         drive(0, '0, 1, rnd_word(), 1, 0);
         checks++; if (reg_in_ready !== 1'b1) begin failures++; $display("FAIL cap_admit%0d got=%0b exp=1", i, reg_in_ready); end
      end
      drive(0, '0, 1, w17, 1, 0);
      checks++; if (reg_in_ready !== 1'b0 || inflight_count !== 5'd16) begin
         failures++; $display("FAIL cap_block got=rdy%0b/cnt%0d exp=rdy0/cnt16", reg_in_ready, inflight_count);
      end
      drive(0, '0, 1, w17, 1, 1);
      checks++; if (out_valid !== 1'b0 || reg_in_ready !== 1'b0) begin
         failures++; $display("FAIL cap_drop got=v%0b/rdy%0b exp=v0/rdy0", out_valid, reg_in_ready);
      end
      drive(0, '0, 1, w17, 1, 0);
      checks++; if (reg_in_ready !== 1'b1 || inflight_count !== 5'd15) begin
         failures++; $display("FAIL cap_reopen got=rdy%0b/cnt%0d exp=rdy1/cnt15", reg_in_ready, inflight_count);
      end
      drive(0, '0, 0, '0, 1, 0);
      checks++; if (out_valid !== 1'b1 || out_data !== w17 || inflight_count !== 5'd16) begin
         failures++; $display("FAIL cap_w17 got=v%0b/%0h/cnt%0d exp=v1/%0h/cnt16", out_valid, out_data, inflight_count, w17);
      end
   endtask

   task automatic test_same_cycle();
      for (int i = 0; i < 5; i++) drive(0, '0, 1, rnd_word(), 1, 0);
      drive(0, '0, 1, rnd_word(), 1, 1);
      checks++; if (reg_in_ready !== 1'b1) begin failures++; $display("FAIL same_rdy got=%0b exp=1", reg_in_ready); end
      drive(0, '0, 0, '0, 1, 0);
      checks++; if (inflight_count !== 5'd5) begin failures++; $display("FAIL same_count got=%0d exp=5", inflight_count); end
      repeat (5) drive(0, '0, 0, '0, 1, 1);
      drive(0, '0, 0, '0, 1, 0);
      checks++; if (inflight_count !== 5'd0 || retire_err !== 1'b0) begin
         failures++; $display("FAIL same_drain got=cnt%0d/err%0b exp=cnt0/err0", inflight_count, retire_err);
      end
      drive(0, '0, 0, '0, 1, 1);
      drive(0, '0, 0, '0, 1, 0);
      checks++; if (inflight_count !== 5'd0 || retire_err !== 1'b1) begin
         failures++; $display("FAIL under_err got=cnt%0d/err%0b exp=cnt0/err1", inflight_count, retire_err);
      end
      drive(0, '0, 1, rnd_word(), 1, 0);
      drive(0, '0, 0, '0, 1, 0);
      checks++; if (retire_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b exp=1", retire_err); end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] x, y;
      x = rnd_word(); y = rnd_word();
      drive(0, '0, 1, x, 1, 0);
      for (int i = 0; i < 3; i++) begin
         drive(1, y, 0, '0, 0, 0);
         checks++; if (out_valid !== 1'b1 || out_data !== x || fb_in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_hold%0d got=v%0b/%0h/rdy%0b exp=v1/%0h/rdy0", i, out_valid, out_data, fb_in_ready, x);
         end
      end
      drive(1, y, 0, '0, 1, 0);
      checks++; if (fb_in_ready !== 1'b1 || out_data !== x) begin
         failures++; $display("FAIL bp_release got=rdy%0b/%0h exp=rdy1/%0h", fb_in_ready, out_data, x);
      end
      drive(0, '0, 0, '0, 1, 0);
      checks++; if (out_valid !== 1'b1 || out_data !== y || out_src !== 1'b1) begin
         failures++; $display("FAIL bp_next got=v%0b/%0h/src%0b exp=v1/%0h/src1", out_valid, out_data, out_src, y);
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] z;
      z = rnd_word();
      for (int i = 0; i < 7; i++) drive(0, '0, 1, rnd_word(), 1, 0);
      drive(0, '0, 0, '0, 0, 0);
      checks++; if (out_valid !== 1'b1 || inflight_count !== 5'd7) begin
         failures++; $display("FAIL mid_pre got=v%0b/cnt%0d exp=v1/cnt7", out_valid, inflight_count);
      end
      fb_in_valid = 1; reg_in_valid = 1; out_ready = 1;
      #2 rst = 0;
      #1;
      checks++; if (out_valid !== 1'b0 || inflight_count !== 5'd0 || fb_in_ready !== 1'b0 || reg_in_ready !== 1'b0) begin
         failures++; $display("FAIL mid_async got=v%0b/cnt%0d/fb%0b/reg%0b exp=0/0/0/0", out_valid, inflight_count, fb_in_ready, reg_in_ready);
      end
      idle_inputs();
      @(negedge clk);
      rst = 1;
      model_reset();
      drive(0, '0, 1, z, 1, 0);
      checks++; if (out_valid !== 1'b0 || reg_in_ready !== 1'b1) begin
         failures++; $display("FAIL mid_hs got=v%0b/rdy%0b exp=v0/rdy1", out_valid, reg_in_ready);
      end
      drive(0, '0, 0, '0, 1, 0);
      checks++; if (out_valid !== 1'b1 || out_data !== z) begin
         failures++; $display("FAIL mid_first got=v%0b/%0h exp=v1/%0h", out_valid, out_data, z);
      end
   endtask

   task automatic test_random();
      bit fv, rv, ordy, ret;
      int rp;
      for (int i = 0; i < 3000; i++) begin
         fv   = ($urandom % 2) == 0;
         rv   = ($urandom % 10) < 7;
         ordy = ($urandom % 4) != 0;
         rp   = ((i / 500) % 2 == 1) ? 2 : 5;
         ret  = (m_cnt > 0) ? (($urandom % rp) == 0) : (($urandom % 60) == 0);
         drive(fv, rnd_word(), rv, rnd_word(), ordy, ret);
         checks++; if (fb_in_ready !== e_fb_rdy || reg_in_ready !== e_reg_rdy) begin
            failures++; $display("FAIL rnd_rdy@%0d got=fb%0b/reg%0b exp=fb%0b/reg%0b", i, fb_in_ready, reg_in_ready, e_fb_rdy, e_reg_rdy);
         end
         checks++; if (out_valid !== m_ov) begin
            failures++; $display("FAIL rnd_valid@%0d got=%0b exp=%0b", i, out_valid, m_ov);
         end
         if (m_ov && q.size() > 0) begin
            checks++; if (out_data !== q[0].data || out_src !== q[0].src) begin
               failures++; $display("FAIL rnd_data@%0d got=%0h/%0b exp=%0h/%0b", i, out_data, out_src, q[0].data, q[0].src);
            end
         end
         checks++; if (int'(inflight_count) != m_cnt || retire_err !== m_err) begin
            failures++; $display("FAIL rnd_cnt@%0d got=%0d/%0b exp=%0d/%0b", i, inflight_count, retire_err, m_cnt, m_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_reg_abc();
      test_burst();
      do_reset();
      test_cap();
      do_reset();
      test_same_cycle();
      do_reset();
      test_backpressure();
      do_reset();
      test_reset_mid();
      do_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
